mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter that shares one single-port, 16-bit, byte-laned memory between the core's instruction-fetch port and its load/store port. It sits between the datapath and the unified memory. It grants one access at a time, with data priority, and sequences each access through issue, latency wait and response. It generates byte-lane enables and byte steering, flags misaligned halfword accesses, and returns a `stall` that freezes the PC and register-file write while an access is outstanding.

## Interface
- `MEM_LAT`, default 2: cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range is 1..7.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request. Held with `if_addr` until `if_ack`.
- `if_addr` in 16: fetch address. Bit 0 is ignored and forced to 0.
- `if_rdata` out 16: fetched halfword. Valid when `if_ack` is high; held until the next fetch ack.
- `if_ack` out 1: one-cycle completion pulse for a fetch.
- `d_req` in 1: data request. Held with all other `d_*` inputs until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_bh` in 1: 1 = halfword, 0 = byte.
- `d_addr` in 16: data byte address.
- `d_wdata` in 16: store data. Only bits [7:0] are used for byte stores.
- `d_rdata` out 16: load result. Byte loads return the selected lane zero-extended. Held until the next data ack.
- `d_ack` out 1: one-cycle completion pulse for a data access.
- `d_err` out 1: pulses with `d_ack` when a halfword access has `d_addr[0]=1`.
- `mem_en` out 1: memory access strobe, high for exactly one cycle per access.
- `mem_we` out 1: write strobe, qualified by `mem_en`.
- `mem_be` out 2: byte enables. Bit 1 = high byte (odd address), bit 0 = low byte.
- `mem_addr` out 16: halfword-aligned address. Bit 0 is always 0.
- `mem_wdata` out 16: write data.
- `mem_rdata` in 16: read data, valid `MEM_LAT` cycles after the `mem_en` cycle.
- `stall` out 1: `(if_req & ~if_ack) | (d_req & ~d_ack)`. This is combinational.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. The state encoding, the grant register (`sel_d`) and a 3-bit latency counter are all registered.
- **IDLE**
  - If `d_req`: set `sel_d=1` and go to ISSUE.
  - Else if `if_req`: set `sel_d=0` and go to ISSUE.
  - Else stay in IDLE.
  - Priority is fixed: data wins, because a data access belongs to the instruction already fetched.
- **Misaligned access:** if the grant is data with `d_bh=1` and `d_addr[0]=1`, go to RESP directly instead of ISSUE. No `mem_en` is issued. `d_err=1` in RESP, and `d_rdata` is unchanged.
- **ISSUE** lasts one cycle. `mem_en=1`, and `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are driven from the granted port.
  - Stores go next to RESP.
  - Loads and fetches load the counter with `MEM_LAT-1` and go to WAIT.
- **WAIT** lasts `MEM_LAT` cycles. The counter decrements each cycle.
  - When the counter is 0, `mem_rdata` is captured into the granted port's rdata register and the FSM goes to RESP.
- **RESP** lasts one cycle. The granted port's ack is 1, then the FSM goes to IDLE. Requests present during RESP are not sampled.
- **Lane rules**
  - Fetch: `mem_be=11`.
  - Halfword: `mem_be=11`, `mem_wdata=d_wdata`.
  - Byte: `mem_be = d_addr[0] ? 10 : 01`, `mem_wdata={d_wdata[7:0],d_wdata[7:0]}`. The load result is `{8'b0, d_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]}`.
- Outside ISSUE, `mem_en`, `mem_we` and `mem_be` are 0, and `mem_addr` and `mem_wdata` hold their last values.
- **Request withdrawal:** if a request drops before ack, this is a protocol violation. The access in flight still completes and its ack is still pulsed.

## Timing
- Cycle 0 is the cycle in which a request is visible while the FSM is IDLE.
- Load or fetch:
  - ISSUE in cycle 1.
  - WAIT in cycles 2..1+`MEM_LAT`, with `mem_rdata` sampled at the end of cycle 1+`MEM_LAT`.
  - Ack in cycle 2+`MEM_LAT`.
  - IDLE in cycle 3+`MEM_LAT`.
- Store: ISSUE in cycle 1, ack in cycle 2, IDLE in cycle 3.
- Misaligned access: ack and `d_err` in cycle 1.
- Back-to-back accesses: the earliest next ISSUE is 2 cycles after an ack.
- `if_ack` and `d_ack` are never high in the same cycle.
- **Reset** (synchronous, overrides everything, including mid-WAIT):
  - State goes to IDLE; counter and `sel_d` go to 0.
  - All outputs go to 0, including `if_rdata`, `d_rdata`, `mem_addr` and `mem_wdata`.
  - Late `mem_rdata` from an aborted access is ignored.
  - The first ISSUE after reset is no earlier than cycle 1 after reset is deasserted.

## Test plan
- **Fetch alone:** `MEM_LAT=2`, `if_req=1`, `if_addr=0x0013`. Expect `mem_en` in cycle 1 with `mem_addr=0x0012` and `mem_be=11`. Memory returns 0xA5C3 in cycle 3. Expect `if_ack=1` and `if_rdata=0xA5C3` in cycle 4. `stall` is 1 for cycles 0..3 and 0 in cycle 4.
- **Simultaneous requests:** `if_req` and `d_req` (a halfword load from 0x0040) both high in cycle 0. Expect `d_ack` in cycle 4 and the fetch ISSUE in cycle 6, then `if_ack` in cycle 9. `busy` is 0 in cycle 5.
- **Byte load, odd address:** `d_addr=0x0101`, memory returns 0x8E22. Expect `mem_be=10` at ISSUE and `d_rdata=0x008E` with `d_ack`.
- **Byte store:** `d_we=1`, `d_bh=0`, `d_addr=0x0200`, `d_wdata=0x1234`. Expect `mem_we=1`, `mem_be=01` and `mem_wdata=0x3434` in cycle 1, and `d_ack` in cycle 2.
- **Misaligned halfword:** `d_bh=1`, `d_addr=0x0007`. Expect no `mem_en`, and `d_ack=d_err=1` in cycle 1.
- **Reset mid-WAIT:** assert `reset` in cycle 2 of a fetch. Expect all outputs 0 and `busy=0` in cycle 3, and no `if_ack` even though memory returns data in cycle 3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 16-bit byte-laned memory between instruction fetch and load/store.
// Data wins arbitration; each access runs ISSUE -> WAIT (loads/fetches) -> RESP.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_bh,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       sel_d;
    logic [2:0] cnt;
    // Attributes of the granted data access, latched so a withdrawn request cannot disturb it.
    logic       is_store;
    logic       is_byte;
    logic       lane_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel_d     <= 1'b0;
            cnt       <= 3'd0;
            is_store  <= 1'b0;
            is_byte   <= 1'b0;
            lane_hi   <= 1'b0;
            if_rdata  <= 16'h0000;
            if_ack    <= 1'b0;
            d_rdata   <= 16'h0000;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 2'b00;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        sel_d    <= 1'b1;
                        is_store <= d_we;
                        is_byte  <= ~d_bh;
                        lane_hi  <= d_addr[0];
                        if (d_bh && d_addr[0]) begin
                            // Misaligned halfword: answer with an error, never touch memory.
                            state <= RESP;
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= d_we;
                            mem_be    <= d_bh ? 2'b11 : (d_addr[0] ? 2'b10 : 2'b01);
                            mem_addr  <= d_addr & 16'hFFFE;
                            mem_wdata <= d_bh ? d_wdata : {d_wdata[7:0], d_wdata[7:0]};
                        end
                    end else if (if_req) begin
                        sel_d    <= 1'b0;
                        is_store <= 1'b0;
                        state    <= ISSUE;
                        mem_en   <= 1'b1;
                        mem_be   <= 2'b11;
                        mem_addr <= if_addr & 16'hFFFE;
                    end
                end
                ISSUE: begin
                    if (is_store) begin
                        state <= RESP;
                        d_ack <= 1'b1;
                    end else begin
                        cnt   <= 3'(MEM_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= RESP;
                        if (sel_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= is_byte ? {8'h00, lane_hi ? mem_rdata[15:8] : mem_rdata[7:0]}
                                               : mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2; each cycle is checked mid-period.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic        d_bh;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(.MEM_LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_bh      (d_bh),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Start a new cycle: inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let outputs settle, well away from either clock edge.
    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 16'h0000;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_bh      = 1'b0;
        d_addr    = 16'h0000;
        d_wdata   = 16'h0000;
        mem_rdata = 16'hDEAD;
        repeat (3) next_cycle();
        settle();
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_mem_en", 16'(mem_en), 16'h0);
        chk("rst_mem_be", 16'(mem_be), 16'h0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_acks", {14'h0, if_ack, d_ack}, 16'h0);
        chk("rst_rdata", if_rdata | d_rdata, 16'h0000);
        chk("rst_stall", 16'(stall), 16'h0);

        next_cycle();
        reset = 1'b0;

        // Fetch alone from 0x0013.
        next_cycle();
        if_req = 1'b1; if_addr = 16'h0013;
        settle();
        chk("f_c0_stall", 16'(stall), 16'h1);
        chk("f_c0_mem_en", 16'(mem_en), 16'h0);
        next_cycle();
        settle();
        chk("f_c1_mem_en", 16'(mem_en), 16'h1);
        chk("f_c1_mem_addr", mem_addr, 16'h0012);
        chk("f_c1_mem_be", 16'(mem_be), 16'h3);
        chk("f_c1_mem_we", 16'(mem_we), 16'h0);
        chk("f_c1_busy", 16'(busy), 16'h1);
        next_cycle();
        settle();
        chk("f_c2_mem_en", 16'(mem_en), 16'h0);
        chk("f_c2_mem_be", 16'(mem_be), 16'h0);
        chk("f_c2_stall", 16'(stall), 16'h1);
        next_cycle();
        mem_rdata = 16'hA5C3;
        settle();
        chk("f_c3_if_ack", 16'(if_ack), 16'h0);
        chk("f_c3_stall", 16'(stall), 16'h1);
        next_cycle();
        mem_rdata = 16'hDEAD;
        settle();
        chk("f_c4_if_ack", 16'(if_ack), 16'h1);
        chk("f_c4_if_rdata", if_rdata, 16'hA5C3);
        chk("f_c4_stall", 16'(stall), 16'h0);
        chk("f_c4_mem_addr_hold", mem_addr, 16'h0012);
        next_cycle();
        if_req = 1'b0;
        settle();
        chk("f_c5_if_ack", 16'(if_ack), 16'h0);
        chk("f_c5_if_rdata_hold", if_rdata, 16'hA5C3);
        chk("f_c5_busy", 16'(busy), 16'h0);

        // Simultaneous fetch and halfword load: data goes first.
        next_cycle();
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_bh = 1'b1; d_addr = 16'h0040;
        next_cycle();
        settle();
        chk("s_c1_mem_en", 16'(mem_en), 16'h1);
        chk("s_c1_mem_addr", mem_addr, 16'h0040);
        chk("s_c1_mem_be", 16'(mem_be), 16'h3);
        next_cycle();
        next_cycle();
        mem_rdata = 16'hBEEF;
        next_cycle();
        mem_rdata = 16'hDEAD;
        settle();
        chk("s_c4_d_ack", 16'(d_ack), 16'h1);
        chk("s_c4_d_rdata", d_rdata, 16'hBEEF);
        chk("s_c4_if_ack", 16'(if_ack), 16'h0);
        chk("s_c4_stall", 16'(stall), 16'h1);
        next_cycle();
        d_req = 1'b0;
        settle();
        chk("s_c5_busy", 16'(busy), 16'h0);
        chk("s_c5_mem_en", 16'(mem_en), 16'h0);
        next_cycle();
        settle();
        chk("s_c6_mem_en", 16'(mem_en), 16'h1);
        chk("s_c6_mem_addr", mem_addr, 16'h0100);
        next_cycle();
        next_cycle();
        mem_rdata = 16'hCAFE;
        settle();
        chk("s_c8_if_ack", 16'(if_ack), 16'h0);
        next_cycle();
        mem_rdata = 16'hDEAD;
        settle();
        chk("s_c9_if_ack", 16'(if_ack), 16'h1);
        chk("s_c9_if_rdata", if_rdata, 16'hCAFE);
        chk("s_c9_d_ack", 16'(d_ack), 16'h0);
        chk("s_c9_d_rdata_hold", d_rdata, 16'hBEEF);
        next_cycle();
        if_req = 1'b0;

        // Byte load from odd address returns the high lane.
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_bh = 1'b0; d_addr = 16'h0101;
        next_cycle();
        settle();
        chk("bo_c1_mem_be", 16'(mem_be), 16'h2);
        chk("bo_c1_mem_addr", mem_addr, 16'h0100);
        next_cycle();
        next_cycle();
        mem_rdata = 16'h8E22;
        next_cycle();
        mem_rdata = 16'hDEAD;
        settle();
        chk("bo_c4_d_ack", 16'(d_ack), 16'h1);
        chk("bo_c4_d_rdata", d_rdata, 16'h008E);
        chk("bo_c4_d_err", 16'(d_err), 16'h0);
        next_cycle();
        d_req = 1'b0;

        // Byte load from even address returns the low lane.
        next_cycle();
        d_req = 1'b1; d_addr = 16'h0102;
        next_cycle();
        settle();
        chk("be_c1_mem_be", 16'(mem_be), 16'h1);
        next_cycle();
        next_cycle();
        mem_rdata = 16'h8E22;
        next_cycle();
        mem_rdata = 16'hDEAD;
        settle();
        chk("be_c4_d_rdata", d_rdata, 16'h0022);
        next_cycle();
        d_req = 1'b0;

        // Byte store replicates the low byte.
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_bh = 1'b0; d_addr = 16'h0200; d_wdata = 16'h1234;
        next_cycle();
        settle();
        chk("bs_c1_mem_en", 16'(mem_en), 16'h1);
        chk("bs_c1_mem_we", 16'(mem_we), 16'h1);
        chk("bs_c1_mem_be", 16'(mem_be), 16'h1);
        chk("bs_c1_mem_wdata", mem_wdata, 16'h3434);
        next_cycle();
        settle();
        chk("bs_c2_d_ack", 16'(d_ack), 16'h1);
        chk("bs_c2_mem_we", 16'(mem_we), 16'h0);
        chk("bs_c2_d_rdata_hold", d_rdata, 16'h0022);
        next_cycle();
        d_req = 1'b0;
        settle();
        chk("bs_c3_busy", 16'(busy), 16'h0);
        chk("bs_c3_mem_wdata_hold", mem_wdata, 16'h3434);

        // Halfword store passes data through on both lanes.
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_bh = 1'b1; d_addr = 16'h0302; d_wdata = 16'hABCD;
        next_cycle();
        settle();
        chk("hs_c1_mem_be", 16'(mem_be), 16'h3);
        chk("hs_c1_mem_wdata", mem_wdata, 16'hABCD);
        chk("hs_c1_mem_addr", mem_addr, 16'h0302);
        next_cycle();
        settle();
        chk("hs_c2_d_ack", 16'(d_ack), 16'h1);
        next_cycle();
        d_req = 1'b0;

        // Misaligned halfword load: error, no memory strobe.
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_bh = 1'b1; d_addr = 16'h0007;
        next_cycle();
        settle();
        chk("ma_c1_mem_en", 16'(mem_en), 16'h0);
        chk("ma_c1_d_ack", 16'(d_ack), 16'h1);
        chk("ma_c1_d_err", 16'(d_err), 16'h1);
        chk("ma_c1_d_rdata_hold", d_rdata, 16'h0022);
        next_cycle();
        d_req = 1'b0;
        settle();
        chk("ma_c2_d_err", 16'(d_err), 16'h0);
        chk("ma_c2_busy", 16'(busy), 16'h0);

        // Reset during WAIT aborts the fetch.
        next_cycle();
        if_req = 1'b1; if_addr = 16'h0020;
        next_cycle();
        settle();
        chk("rw_c1_mem_en", 16'(mem_en), 16'h1);
        next_cycle();
        reset = 1'b1;
        settle();
        chk("rw_c2_busy", 16'(busy), 16'h1);
        next_cycle();
        reset = 1'b0; if_req = 1'b0;
        mem_rdata = 16'h7777;
        settle();
        chk("rw_c3_if_ack", 16'(if_ack), 16'h0);
        chk("rw_c3_busy", 16'(busy), 16'h0);
        chk("rw_c3_mem_addr", mem_addr, 16'h0000);
        chk("rw_c3_mem_wdata", mem_wdata, 16'h0000);
        chk("rw_c3_rdata", if_rdata | d_rdata, 16'h0000);
        next_cycle();
        mem_rdata = 16'hDEAD;
        settle();
        chk("rw_c4_if_ack", 16'(if_ack), 16'h0);
        chk("rw_c4_if_rdata", if_rdata, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
